// File: rtl/zap_decode_link_seq.sv
// Expands link-type branches into a two-uop sequence (link MOV, then branch) ahead of the decoder.
// Optional macro ZAP_BLX_REG_EN adds expansion of BLX Rm into MOV LR,PC followed by BX Rm.
module zap_decode_link_seq #(
  parameter int INSTR_WIDTH = 35,
  parameter int LINK_REG    = 14
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic                   i_fiq,
  input  logic                   i_irq,
  input  logic                   i_clear_from_writeback,
  input  logic                   i_data_stall,
  input  logic                   i_clear_from_alu,
  input  logic                   i_stall_from_issue,
  input  logic [INSTR_WIDTH-1:0] i_instruction,
  input  logic                   i_instruction_valid,
  output logic [INSTR_WIDTH-1:0] o_instruction,
  output logic                   o_instruction_valid,
  output logic                   o_stall_from_decode,
  output logic                   o_fiq,
  output logic                   o_irq,
  output logic [1:0]             o_uop_index,
  output logic                   o_seq_active,
  output logic                   o_und
);

  localparam logic [3:0] LINK = 4'(LINK_REG);

  typedef enum logic {
    S0 = 1'b0,
    S1 = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [3:0]             cond_s;
  logic                   cond_nv_s;
  logic                   bl_enc_s;
  logic                   blx_match_s;
  logic                   blx_und_s;
  logic                   match_s;
  logic                   und_s;
  logic                   kind_blx_s;
  logic [INSTR_WIDTH-1:0] link_uop_s;
  logic [INSTR_WIDTH-1:0] second_uop_s;

  assign cond_s    = i_instruction[31:28];
  assign cond_nv_s = (cond_s == 4'hF);
  assign bl_enc_s  = i_instruction_valid && (i_instruction[27:25] == 3'b101) && i_instruction[24];

`ifdef ZAP_BLX_REG_EN
  logic blx_enc_s;
  logic kind_blx_q;

  assign blx_enc_s   = i_instruction_valid && (i_instruction[27:4] == 24'h12FFF3) && !cond_nv_s;
  assign blx_match_s = blx_enc_s && (i_instruction[3:0] != LINK);
  assign blx_und_s   = blx_enc_s && (i_instruction[3:0] == LINK);
  assign kind_blx_s  = kind_blx_q;

  // Kind tracks the S0 decode so it is captured on the cycle S1 is entered.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      kind_blx_q <= 1'b0;
    end else if (state_q == S0) begin
      kind_blx_q <= blx_match_s;
    end else begin
      kind_blx_q <= kind_blx_q;
    end
  end
`else
  assign blx_match_s = 1'b0;
  assign blx_und_s   = 1'b0;
  assign kind_blx_s  = 1'b0;
`endif

  assign match_s = (bl_enc_s && !cond_nv_s) || blx_match_s;
  assign und_s   = (bl_enc_s && cond_nv_s) || blx_und_s;

  // Build both uops; the link MOV carries no side-band.
  always_comb begin
    link_uop_s        = '0;
    link_uop_s[31:0]  = {cond_s, 8'h1A, 4'h0, LINK, 12'h00F};
    second_uop_s      = i_instruction;
    if (kind_blx_s) begin
      second_uop_s[31:0] = {cond_s, 24'h12FFF1, i_instruction[3:0]};
    end else begin
      second_uop_s[24] = 1'b0;
    end
  end

  // Sequencer advance when no flush or stall intervenes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S0:      state_d = match_s ? S1 : S0;
      S1:      state_d = i_instruction_valid ? S0 : S1;
      default: state_d = S0;
    endcase
  end

  // Flush/stall priority: writeback clear beats data stall beats ALU clear beats issue stall.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q <= S0;
    end else if (i_clear_from_writeback) begin
      state_q <= S0;
    end else if (i_data_stall) begin
      state_q <= state_q;
    end else if (i_clear_from_alu) begin
      state_q <= S0;
    end else if (i_stall_from_issue) begin
      state_q <= state_q;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs follow state and inputs in the same cycle.
  always_comb begin
    o_instruction       = i_instruction;
    o_instruction_valid = i_instruction_valid;
    o_stall_from_decode = 1'b0;
    o_fiq               = i_fiq;
    o_irq               = i_irq;
    o_uop_index         = 2'd0;
    o_seq_active        = 1'b0;
    o_und               = 1'b0;
    if (!i_reset_n) begin
      o_instruction_valid = 1'b0;
      o_fiq               = 1'b0;
      o_irq               = 1'b0;
    end else if (state_q == S1) begin
      o_instruction = second_uop_s;
      o_fiq         = 1'b0;
      o_irq         = 1'b0;
      o_uop_index   = 2'd1;
      o_seq_active  = 1'b1;
    end else if (match_s) begin
      o_instruction       = link_uop_s;
      o_instruction_valid = 1'b1;
      o_stall_from_decode = 1'b1;
      o_fiq               = 1'b0;
      o_irq               = 1'b0;
    end else begin
      o_und = und_s;
    end
  end

endmodule

// File: tb/tb_zap_decode_link_seq.sv
// Directed bench for zap_decode_link_seq: per-cycle model compare plus hand-computed literal checks.
module tb_zap_decode_link_seq;

  localparam int         W      = 35;
  localparam logic [3:0] LINK_A = 4'd14;
`ifdef ZAP_BLX_REG_EN
  localparam bit BLX_EN = 1'b1;
`else
  localparam bit BLX_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n, fiq, irq, clr_wb, dstall, clr_alu, issue, valid;
  logic [W-1:0] instr;
  logic [W-1:0] o_instr;
  logic         o_valid, o_stall, o_fiq, o_irq, o_seq, o_und;
  logic [1:0]   o_uop;

  logic [W-1:0] b_instr;
  logic [W-1:0] b_o_instr;
  logic         b_o_valid, b_o_stall, b_o_fiq, b_o_irq, b_o_seq, b_o_und;
  logic [1:0]   b_o_uop;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  zap_decode_link_seq #(.INSTR_WIDTH(W), .LINK_REG(14)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_fiq(fiq), .i_irq(irq),
    .i_clear_from_writeback(clr_wb), .i_data_stall(dstall), .i_clear_from_alu(clr_alu),
    .i_stall_from_issue(issue), .i_instruction(instr), .i_instruction_valid(valid),
    .o_instruction(o_instr), .o_instruction_valid(o_valid), .o_stall_from_decode(o_stall),
    .o_fiq(o_fiq), .o_irq(o_irq), .o_uop_index(o_uop), .o_seq_active(o_seq), .o_und(o_und)
  );

  zap_decode_link_seq #(.INSTR_WIDTH(W), .LINK_REG(13)) dut_lr13 (
    .i_clk(clk), .i_reset_n(rst_n), .i_fiq(1'b0), .i_irq(1'b0),
    .i_clear_from_writeback(1'b0), .i_data_stall(1'b0), .i_clear_from_alu(1'b0),
    .i_stall_from_issue(1'b0), .i_instruction(b_instr), .i_instruction_valid(1'b1),
    .o_instruction(b_o_instr), .o_instruction_valid(b_o_valid), .o_stall_from_decode(b_o_stall),
    .o_fiq(b_o_fiq), .o_irq(b_o_irq), .o_uop_index(b_o_uop), .o_seq_active(b_o_seq), .o_und(b_o_und)
  );

  task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: are we between the two uops of a sequence, and was it a BLX?
  logic m_seq = 1'b0;
  logic m_blx = 1'b0;

  typedef struct packed {
    logic [W-1:0] instr;
    logic         valid, stall, irq, fiq, seq, und;
    logic [1:0]   uop;
  } exp_t;

  function automatic bit is_bl(input logic [W-1:0] x);
    return x[27:24] == 4'hB;
  endfunction

  function automatic bit is_blx(input logic [W-1:0] x);
    return BLX_EN && (x[27:4] == 24'h12FFF3);
  endfunction

  function automatic bit expands(input logic [W-1:0] x, input logic v);
    return v && (x[31:28] != 4'hF) && (is_bl(x) || (is_blx(x) && x[3:0] != LINK_A));
  endfunction

  function automatic bit rejects(input logic [W-1:0] x, input logic v);
    return v && ((is_bl(x) && x[31:28] == 4'hF) ||
                 (is_blx(x) && x[31:28] != 4'hF && x[3:0] == LINK_A));
  endfunction

  function automatic exp_t model_out(input logic rn, input logic [W-1:0] x, input logic v,
                                     input logic ir, input logic fq);
    exp_t e;
    e.instr = x; e.valid = v; e.stall = 1'b0; e.irq = ir; e.fiq = fq;
    e.seq = 1'b0; e.und = 1'b0; e.uop = 2'd0;
    if (!rn) begin
      e.valid = 1'b0; e.irq = 1'b0; e.fiq = 1'b0;
    end else if (m_seq) begin
      e.seq = 1'b1; e.uop = 2'd1; e.irq = 1'b0; e.fiq = 1'b0;
      if (m_blx) e.instr = {x[34:28], 24'h12FFF1, x[3:0]};
      else       e.instr = x - (x & (35'd1 << 24));
    end else if (expands(x, v)) begin
      e.instr = ({3'b000, x[31:28], 28'h0} | 35'h001A0000F | (35'(LINK_A) << 12));
      e.stall = 1'b1; e.irq = 1'b0; e.fiq = 1'b0;
    end else begin
      e.und = rejects(x, v);
    end
    return e;
  endfunction

  // Model state update with the flush/stall priority order.
  always @(posedge clk) begin
    if (!rst_n)            m_seq <= 1'b0;
    else if (clr_wb)       m_seq <= m_seq & 1'b0;
    else if (dstall)       m_seq <= m_seq;
    else if (clr_alu)      m_seq <= 1'b0;
    else if (issue)        m_seq <= m_seq;
    else if (m_seq)        m_seq <= !valid;
    else if (expands(instr, valid)) begin
      m_seq <= 1'b1;
      m_blx <= is_blx(instr);
    end
  end

  // Per-cycle compare on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    e = model_out(rst_n, instr, valid, irq, fiq);
    chk("valid", 36'(o_valid), 36'(e.valid));
    chk("stall", 36'(o_stall), 36'(e.stall));
    chk("irq",   36'(o_irq),   36'(e.irq));
    chk("fiq",   36'(o_fiq),   36'(e.fiq));
    chk("seq",   36'(o_seq),   36'(e.seq));
    chk("und",   36'(o_und),   36'(e.und));
    if (rst_n && (e.valid || !e.seq)) begin
      chk("instr", 36'(o_instr), 36'(e.instr));
      chk("uop",   36'(o_uop),   36'(e.uop));
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; fiq = 1'b1; irq = 1'b1; clr_wb = 1'b0; dstall = 1'b0; clr_alu = 1'b0;
    issue = 1'b0; valid = 1'b1; instr = 35'h0EB000010; b_instr = 35'h00B000004;
    tick; tick; #2;
    chk("rst_valid", 36'(o_valid), 36'h0);
    chk("rst_stall", 36'(o_stall), 36'h0);
    rst_n = 1'b1; #1;
    chk("bl_uop0", 36'(o_instr), 36'h00E1A0E00F);
    chk("bl_stall", 36'(o_stall), 36'h1);
    chk("bl_irq_masked", 36'(o_irq), 36'h0);
    chk("lr13_uop0", 36'(b_o_instr[31:0]), 36'h001A0D00F);
    tick; #2;
    chk("bl_uop1", 36'(o_instr), 36'h00EA000010);
    chk("bl_uop1_idx", 36'(o_uop), 36'h1);
    tick; instr = 35'h0E1A00000; #2;
    chk("pass_irq", 36'(o_irq), 36'h1);

    // Side-band BL
    tick; instr = 35'h1EB000010; #2;
    chk("sb_uop0", 36'(o_instr), 36'h00E1A0E00F);
    tick; #2;
    chk("sb_uop1", 36'(o_instr), 36'h01EA000010);
    chk("sb_stall", 36'(o_stall), 36'h0);
    tick; instr = 35'h1E3A01001; #2;
    chk("sb_pass", 36'(o_instr), 36'h01E3A01001);

    // Issue stall holds S1
    tick; instr = 35'h0EB000010; #2;
    tick; issue = 1'b1; #2;
    tick; #2;
    tick; #2;
    chk("issue_hold", 36'(o_instr), 36'h00EA000010);
    tick; issue = 1'b0; #2;
    chk("issue_hold_seq", 36'(o_seq), 36'h1);
    tick; instr = 35'h0E1A00000; #2;
    chk("issue_done", 36'(o_seq), 36'h0);

    // Data stall outranks ALU clear
    tick; instr = 35'h0EB000010; #2;
    tick; dstall = 1'b1; clr_alu = 1'b1; #2;
    tick; #2;
    chk("dstall_hold", 36'(o_seq), 36'h1);
    tick; dstall = 1'b0; clr_alu = 1'b0; #2;
    tick; instr = 35'h0E1A00000; #2;

    // Writeback clear aborts the sequence
    tick; instr = 35'h0EB000010; #2;
    tick; clr_wb = 1'b1; #2;
    tick; clr_wb = 1'b0; instr = 35'h0E3A01001; #2;
    chk("wb_abort_seq", 36'(o_seq), 36'h0);
    chk("wb_abort_pass", 36'(o_instr), 36'h00E3A01001);

    // Clear coincident with a BL match keeps S0
    tick; instr = 35'h0EB000010; clr_alu = 1'b1; #2;
    tick; clr_alu = 1'b0; #2;
    chk("clr_match_s0", 36'(o_seq), 36'h0);
    tick; #2;
    tick; instr = 35'h0E1A00000; #2;

    // cond = NV BL is flagged, not expanded
    tick; instr = 35'h0FB000010; #2;
    chk("nv_und", 36'(o_und), 36'h1);
    chk("nv_pass", 36'(o_instr), 36'h00FB000010);

    // Invalid input in S1 waits
    tick; instr = 35'h0EB000010; #2;
    tick; valid = 1'b0; #2;
    tick; #2;
    chk("s1_wait_valid", 36'(o_valid), 36'h0);
    tick; valid = 1'b1; #2;
    chk("s1_resume", 36'(o_instr), 36'h00EA000010);
    tick; instr = 35'h0E1A00000; #2;

    // BLX register form
    tick; instr = 35'h0E12FFF33; #2;
`ifdef ZAP_BLX_REG_EN
    chk("blx_uop0", 36'(o_instr), 36'h00E1A0E00F);
    tick; #2;
    chk("blx_uop1", 36'(o_instr), 36'h00E12FFF13);
    tick; instr = 35'h0E12FFF3E; #2;
    chk("blx_lr_und", 36'(o_und), 36'h1);
`else
    chk("blx_pass", 36'(o_instr), 36'h00E12FFF33);
    tick; instr = 35'h0E12FFF3E; #2;
    chk("blx_lr_no_und", 36'(o_und), 36'h0);
`endif
    tick; instr = 35'h0EA000010; #2;
    chk("b_pass", 36'(o_instr), 36'h00EA000010);
    tick;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/zap_decode_link_seq.md
Name: zap_decode_link_seq

Overview:
- Parametrised successor to the decode-front BL expander; converts link-type branches into micro-op (uop) sequences ahead of the decoder.
- BL becomes MOV LR,PC then B; with the optional feature, BLX Rm becomes MOV LR,PC then BX Rm.
- Sits between the memory FSM output and the decoder, and drives the fetch/PC stall.
- Adds a configurable link register, side-band width, uop index/active outputs, data-stall hold and an undefined-case flag.

Parameters:
- INSTR_WIDTH, 35, instruction bus width (≥32); bits [INSTR_WIDTH-1:32] are side-band.
- LINK_REG, 14, 4-bit register index written by the link uop.

Ports:
- i_clk  in  1  clock.
- i_reset_n  in  1  synchronous active-low reset.
- i_fiq  in  1  FIQ level.
- i_irq  in  1  IRQ level.
- i_clear_from_writeback  in  1  flush, highest priority.
- i_data_stall  in  1  data-side stall.
- i_clear_from_alu  in  1  flush from ALU.
- i_stall_from_issue  in  1  issue stall, lowest priority.
- i_instruction  in  INSTR_WIDTH  instruction from memory FSM.
- i_instruction_valid  in  1  instruction valid.
- o_instruction  out  INSTR_WIDTH  uop to decoder.
- o_instruction_valid  out  1  uop valid.
- o_stall_from_decode  out  1  hold fetch and PC.
- o_fiq  out  1  gated FIQ.
- o_irq  out  1  gated IRQ.
- o_uop_index  out  2  0 = first or passthrough, 1 = second uop.
- o_seq_active  out  1  high while in S1.
- o_und  out  1  instruction not expanded; decoder must trap it as undefined.

Behaviour:
- One clock (i_clk); reset is synchronous and active-low (i_reset_n). On reset: state S0.
- While i_reset_n = 0, outputs are forced: o_instruction_valid = 0, o_stall_from_decode = 0, o_irq = o_fiq = 0, o_und = 0, o_uop_index = 0, o_seq_active = 0.
- Outputs are combinational from state and inputs (zero added latency); state is registered.
- Default, S0 with no match: outputs pass inputs through; stall = 0; uop_index = 0.
- BL match (S0, valid, [27:25] = 101, [24] = 1, cond ≠ 4'hF):
  - Output MOV link = {side-band zeroed, cond, 8'h1A, 4'h0, LINK_REG[3:0], 12'h00F}; valid = 1.
  - Stall = 1; irq/fiq = 0; next state S1, kind = BL.
- BL encoding with cond = 4'hF: passthrough, o_und = 1, no expansion.
- S1 (kind BL):
  - Output i_instruction with bit 24 cleared; side-band preserved.
  - uop_index = 1; seq_active = 1; stall = 0; irq/fiq = 0; next state S0.
- S1 with i_instruction_valid = 0: outputs invalid, irq/fiq = 0, state held in S1 (sequence resumes when valid returns).
- Kind is latched on entry to S1.
- State-update priority:
  - !i_reset_n → S0.
  - clear_from_writeback → S0.
  - data_stall → hold.
  - clear_from_alu → S0.
  - stall_from_issue → hold.
  - otherwise next state.
- During a hold in S0-with-match or S1, outputs stay identical each cycle; stall stays asserted in S0-with-match.
- A clear in S1 aborts the sequence; the second uop is never issued.
- A clear coincident with a BL match in S0 leaves the state in S0.

Optional Feature:
- Macro: ZAP_BLX_REG_EN.
- Defined:
  - S0 match on [27:4] = 24'h12FFF3 with cond ≠ 4'hF.
  - If Rm ≠ LINK_REG: uop0 = link MOV (as BL), go to S1 with kind BLX; S1 outputs {side-band, cond, 24'h12FFF1, Rm} (BX Rm), uop_index = 1.
  - If Rm == LINK_REG: passthrough, o_und = 1, no expansion.
- Undefined: BLX register encodings pass through unmodified, o_und = 0, and the kind latch is not built.

Test Plan:
- Reset: i_reset_n = 0 for 2 clocks with valid BL 0xEB000010 → valid = 0, stall = 0; release → first cycle outputs 0x0E1A0E00F (35-bit), stall = 1, irq = 0 with i_irq = 1.
- BL 0x1EB000010 (side-band = 1): cycle 0 → 0x0E1A0E00F, stall = 1; cycle 1 → 0x1EA000010, uop_index = 1, stall = 0; cycle 2 → passthrough, irq follows i_irq.
- BL, then i_stall_from_issue = 1 for 3 cycles in S1 → S1 output repeated 3 cycles; then S0. Repeat with i_data_stall during a clear_from_alu → hold wins.
- i_clear_from_writeback in S1 → next cycle S0, next instruction passes through, no branch uop.
- LINK_REG = 13, BL 0x0B000004 → uop0 = 0x01A0D00F.
- ZAP_BLX_REG_EN: 0xE12FFF33 → uop0 = 0xE1A0E00F, uop1 = 0xE12FFF13. Then 0xE12FFF3E → passthrough, o_und = 1.
